// File: rtl/alu_arbiter.sv
// alu_arbiter: grants one of two requesters access to a shared external 8-bit ALU,
// registers the winning operands, captures the result and returns it tagged with the requester id.
module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [2:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [2:0] req1_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_out,
  input  logic       alu_zero,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       rsp_zero,
  output logic       rsp_err,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t r_state;
  logic   r_last_grant;
  logic   w_idle, w_gnt0, w_gnt1;
  // req0 wins on a tie unless round-robin says it went last
  assign w_idle     = (r_state == IDLE) && !reset;
  assign w_gnt0     = w_idle && req0_valid && (!req1_valid || !RR_EN || r_last_grant);
  assign w_gnt1     = w_idle && req1_valid && !w_gnt0;
  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign busy       = (r_state != IDLE);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      alu_a        <= 8'h00;
      alu_b        <= 8'h00;
      alu_op       <= 3'b000;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= 8'h00;
      rsp_zero     <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_gnt0 || w_gnt1) begin
          alu_a   <= w_gnt1 ? req1_a : req0_a;
          alu_b   <= w_gnt1 ? req1_b : req0_b;
          alu_op  <= w_gnt1 ? req1_op : req0_op;
          rsp_id  <= w_gnt1;
          r_state <= EXEC;
        end
        EXEC: begin
          rsp_data  <= alu_out;
          rsp_zero  <= alu_zero;
          rsp_err   <= (alu_op == 3'b111);
          rsp_valid <= 1'b1;
          r_state   <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid    <= 1'b0;
          r_last_grant <= rsp_id;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench; a round-robin DUT plus a fixed-priority DUT.
module tb_alu_arbiter;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic [7:0] alu_a, alu_b, alu_out, rsp_data;
  logic [2:0] alu_op;
  logic       alu_zero, rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
  logic       f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready;
  logic [7:0] f_alu_a, f_alu_b, f_alu_out, f_rsp_data;
  logic [2:0] f_alu_op;
  logic       f_alu_zero, f_rsp_valid, f_rsp_ready, f_rsp_id, f_rsp_zero, f_rsp_err, f_busy;
  logic       f_phase = 1'b0;
  typedef struct packed {logic id; logic [7:0] data; logic zero; logic err;} rsp_t;
  rsp_t q[$], fq[$];
  int n_cmp = 0, n_bad = 0;
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [7:0] r;
    case (op)
      3'b000: r = a + b;
      3'b001: r = a - b;
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      3'b101: r = a << b[2:0];
      3'b110: r = {7'd0, $signed(a) < $signed(b)};
      default: r = 8'h00;
    endcase
    return {r == 8'h00, r};
  endfunction
  assign {alu_zero, alu_out}     = alu_f(alu_a, alu_b, alu_op);
  assign {f_alu_zero, f_alu_out} = alu_f(f_alu_a, f_alu_b, f_alu_op);
  alu_arbiter #(.RR_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );
  alu_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .reset(reset),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_a(8'h11), .req0_b(8'h22), .req0_op(3'b000),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_a(8'h40), .req1_b(8'h01), .req1_op(3'b001),
    .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_op(f_alu_op), .alu_out(f_alu_out), .alu_zero(f_alu_zero),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_id(f_rsp_id), .rsp_data(f_rsp_data),
    .rsp_zero(f_rsp_zero), .rsp_err(f_rsp_err), .busy(f_busy)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask
  always @(negedge clk) begin
    rsp_t e;
    if (!reset && rsp_valid && rsp_ready) begin
      if (q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_zero", rsp_zero, e.zero);
        chk("rsp_err", rsp_err, e.err);
      end
    end
    if (!reset) chk("ready_onehot", req0_ready && req1_ready, 32'd0);
  end
  always @(negedge clk) begin
    rsp_t e;
    if (!reset && f_rsp_valid && f_rsp_ready) begin
      if (fq.size() == 0) chk("fp_rsp_unexpected", 32'd1, 32'd0);
      else begin
        e = fq.pop_front();
        chk("fp_rsp_id", f_rsp_id, e.id);
        chk("fp_rsp_data", f_rsp_data, e.data);
      end
    end
    if (f_phase) chk("fp_req1_ready", f_req1_ready, 32'd0);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input logic [7:0] ed, input logic ez, input logic ee);
    int k;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    q.push_back('{id: id, data: ed, zero: ez, err: ee});
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) break;
    end
    if (k == 50) timeout("accept");
    tick();
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask
  task automatic drain();
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) break;
    end
    if (k == 50) timeout("drain");
    tick();
  endtask
  task automatic both(input int n);
    int acc, k;
    req0_a = 8'h11; req0_b = 8'h22; req0_op = 3'b000;
    req1_a = 8'h40; req1_b = 8'h01; req1_op = 3'b001;
    req0_valid = 1'b1; req1_valid = 1'b1;
    acc = 0;
    for (k = 0; k < 100 && acc < n; k++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) acc++;
    end
    if (acc < n) timeout("both_accepts");
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end
  initial begin
    int acc, k;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready = 1'b1; f_rsp_ready = 1'b1; f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    #1 reset = 1'b1;
    req0_valid = 1'b1;
    @(negedge clk);
    chk("rst_req0_ready", req0_ready, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_rsp_valid", rsp_valid, 32'd0);
    chk("rst_alu", {alu_a, alu_b, alu_op}, 32'd0);
    chk("rst_rsp", {rsp_id, rsp_data, rsp_zero, rsp_err}, 32'd0);
    req0_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    // ADD with explicit latency checks
    req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h03; req0_op = 3'b000;
    q.push_back('{id: 1'b0, data: 8'h08, zero: 1'b0, err: 1'b0});
    @(negedge clk);
    chk("t1_ready_cycle0", req0_ready, 32'd1);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_exec_busy", busy, 32'd1);
    chk("t1_exec_rsp_valid", rsp_valid, 32'd0);
    chk("t1_alu_regs", {alu_a, alu_b, alu_op}, {8'h05, 8'h03, 3'b000});
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 32'd1);
    @(negedge clk);
    chk("t1_busy_clear", busy, 32'd0);
    tick();
    issue(1'b0, 8'h02, 8'h07, 3'b110, 8'h01, 1'b0, 1'b0);
    drain();
    issue(1'b1, 8'h33, 8'h33, 3'b001, 8'h00, 1'b1, 1'b0);
    drain();
    // round-robin, both valid: 0,1,0,1
    q.push_back('{id: 1'b0, data: 8'h33, zero: 1'b0, err: 1'b0});
    q.push_back('{id: 1'b1, data: 8'h3F, zero: 1'b0, err: 1'b0});
    q.push_back('{id: 1'b0, data: 8'h33, zero: 1'b0, err: 1'b0});
    q.push_back('{id: 1'b1, data: 8'h3F, zero: 1'b0, err: 1'b0});
    both(4);
    drain();
    // fixed priority: req0 every time
    for (int i = 0; i < 4; i++) fq.push_back('{id: 1'b0, data: 8'h33, zero: 1'b0, err: 1'b0});
    f_phase = 1'b1; f_req0_valid = 1'b1; f_req1_valid = 1'b1;
    acc = 0;
    for (k = 0; k < 100 && acc < 4; k++) begin
      @(negedge clk);
      if (f_req0_ready) acc++;
    end
    if (acc < 4) timeout("fp_accepts");
    tick();
    f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    for (k = 0; k < 50 && (fq.size() != 0 || f_busy); k++) @(negedge clk);
    if (k == 50) timeout("fp_drain");
    f_phase = 1'b0;
    tick();
    // backpressure in RESP
    rsp_ready = 1'b0;
    issue(1'b1, 8'h10, 8'h20, 3'b000, 8'h30, 1'b0, 1'b0);
    req0_valid = 1'b1; req0_a = 8'h09; req0_b = 8'h04; req0_op = 3'b001;
    q.push_back('{id: 1'b0, data: 8'h05, zero: 1'b0, err: 1'b0});
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    if (k == 20) timeout("bp_rsp_valid");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_rsp_stable", {rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err}, {1'b1, 1'b1, 8'h30, 1'b0, 1'b0});
      chk("bp_readies", {req0_ready, req1_ready}, 32'd0);
      chk("bp_busy", busy, 32'd1);
    end
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_accept_in_resp", req0_ready, 32'd0);
    @(negedge clk);
    chk("bp_next_accept", req0_ready, 32'd1);
    tick();
    req0_valid = 1'b0;
    drain();
    issue(1'b0, 8'hFF, 8'h00, 3'b111, 8'h00, 1'b1, 1'b1);
    drain();
    // reset during EXEC drops the op and restores req0 priority
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01; req0_op = 3'b000;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req0_ready) break;
    end
    if (k == 20) timeout("rst_exec_accept");
    tick();
    req0_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rx_rsp_valid", rsp_valid, 32'd0);
    chk("rx_alu", {alu_a, alu_b, alu_op}, 32'd0);
    chk("rx_busy", busy, 32'd0);
    tick();
    reset = 1'b0;
    q.push_back('{id: 1'b0, data: 8'h33, zero: 1'b0, err: 1'b0});
    q.push_back('{id: 1'b1, data: 8'h3F, zero: 1'b0, err: 1'b0});
    both(2);
    drain();
    chk("queue_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational 8-bit ALU between two requesters (req0, req1), e.g. the pipeline execute stage and a debug/branch-compare unit.
- Arbitrates with round-robin or fixed priority, registers the winning operands onto the ALU inputs and captures the ALU result.
- Returns the result on a shared response channel tagged with the requester id, using valid/ready handshakes on both sides.

Parameters:
- RR_EN, 1, 1 = round-robin grant; 0 = fixed priority, req0 always wins.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 accepted this cycle when high together with req0_valid.
- req0_a  input  8  operand a.
- req0_b  input  8  operand b.
- req0_op  input  3  ALU op code (000 ADD … 110 SLT; 111 illegal).
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- alu_a  output  8  registered operand a to the ALU.
- alu_b  output  8  registered operand b to the ALU.
- alu_op  output  3  registered op code to the ALU.
- alu_out  input  8  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_zero  input  1  ALU zero flag.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer takes the response.
- rsp_id  output  1  requester that owns the response.
- rsp_data  output  8  captured ALU result.
- rsp_zero  output  1  captured zero flag.
- rsp_err  output  1  op was 3'b111 (illegal).
- busy  output  1  high when not in IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP. All registers are reset asynchronously.
- Reset values:
  - state = IDLE; last_grant = 1 (so req0 wins first).
  - alu_a = alu_b = 0; alu_op = 3'b000.
  - rsp_valid = 0; rsp_id = 0; rsp_data = 0; rsp_zero = 0; rsp_err = 0.
- req*_ready and the grant are combinational:
  - Ready is high only in IDLE, and only for the granted requester; never high for both.
  - Grant in IDLE: if exactly one valid, grant it. If both valid, RR_EN = 1 grants the requester != last_grant; RR_EN = 0 grants req0.
  - A requester's ready does not depend on its own valid being held. The grant is recomputed every cycle; there is no lock before acceptance.
- IDLE, on accept (valid & ready):
  - Latch the winner's a, b, op into alu_a/alu_b/alu_op and its id into rsp_id.
  - Go to EXEC.
  - Without an accept, stay in IDLE; alu_* hold their last values.
- EXEC (exactly 1 cycle):
  - Capture alu_out into rsp_data and alu_zero into rsp_zero.
  - rsp_err = (alu_op == 3'b111); rsp_data and rsp_zero are still captured as-is (ALU gives 0 / 1).
  - Set rsp_valid = 1 and go to RESP.
- RESP:
  - rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err stay stable until rsp_ready is high.
  - On rsp_valid & rsp_ready: clear rsp_valid, set last_grant = rsp_id, go to IDLE.
  - The next accept occurs no earlier than the cycle after IDLE is re-entered.
- Latency: accept at edge N, alu_* valid after N, rsp_valid high after edge N+1. Minimum 3 cycles per operation with rsp_ready held high.
- Requests arriving while busy wait; requesters hold valid and their operands stable until ready.
- In fixed-priority mode, req1 can starve; this is intended.
- Reset asserted in any state: immediately returns to reset values. The in-flight operation is dropped with no response; ready is low while reset is high.
- No arithmetic inside the block; all widths are passed through unchanged.

Test Plan:
- req0 ADD a=8'h05, b=8'h03, rsp_ready=1 -> req0_ready in cycle 0; after 2 edges rsp_valid=1, rsp_id=0, rsp_data=8'h08, rsp_zero=0, rsp_err=0; busy clears the next cycle.
- req1 SUB a=8'h33, b=8'h33 -> rsp_id=1, rsp_data=8'h00, rsp_zero=1. req0 SLT a=8'h02, b=8'h07 -> rsp_data=8'h01.
- RR_EN=1, both valid continuously for 4 ops -> grant order 0,1,0,1. With RR_EN=0 -> 0,0,0,0, and req1_ready is never high.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, both readies low, busy=1. When rsp_ready rises, the transfer completes and the next accept happens one cycle later.
- Illegal op: req0_op=3'b111, a=8'hFF -> rsp_err=1, rsp_data=8'h00, rsp_zero=1.
- Assert reset for 1 cycle during EXEC -> rsp_valid=0, alu_*=0, state IDLE. After release, req0 (valid with req1) is granted first.
